// File: rtl/l1ca_sig_gen.sv
// GPS L1 C/A transmit baseband generator: one-SV PRN chip stream, optionally BPSK-modulated by nav bits.
// Nav handshake and modulation are built only when L1CA_NAV_MOD_EN is defined; otherwise the output is pure PRN.
module l1ca_sig_gen #(
   parameter int NCO_W          = 32,
   parameter int EPOCHS_PER_BIT = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [4:0]       sv,
   input  logic [NCO_W-1:0] code_rate,
   input  logic [9:0]       code_phase_init,
   input  logic             nav_bit,
   input  logic             nav_valid,
   output logic             nav_ready,
   output logic [1:0]       sample_o,
   output logic [9:0]       chip_idx,
   output logic             epoch,
   output logic             bit_edge,
   output logic             busy,
   output logic             nav_underflow
);
   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_LOAD    = 2'd1;
   localparam logic [1:0]  S_RUN     = 2'd2;
   localparam logic [9:0]  LAST_CHIP = 10'd1022;
   localparam logic [10:1] LFSR_SEED = 10'h3FF;
   localparam logic [4:0]  EPB       = 5'(EPOCHS_PER_BIT);
   localparam logic [1:0]  SMP_POS   = 2'b01;
   localparam logic [1:0]  SMP_NEG   = 2'b11;
   localparam logic [1:0]  SMP_ZERO  = 2'b00;

   // G2 phase-select tap pair {t1,t2} for PRN sv+1.
   function automatic logic [7:0] phase_taps(input logic [4:0] s);
      logic [7:0] t;
      case (s)
         5'd0:    t = {4'd2, 4'd6};
         5'd1:    t = {4'd3, 4'd7};
         5'd2:    t = {4'd4, 4'd8};
         5'd3:    t = {4'd5, 4'd9};
         5'd4:    t = {4'd1, 4'd9};
         5'd5:    t = {4'd2, 4'd10};
         5'd6:    t = {4'd1, 4'd8};
         5'd7:    t = {4'd2, 4'd9};
         5'd8:    t = {4'd3, 4'd10};
         5'd9:    t = {4'd2, 4'd3};
         5'd10:   t = {4'd3, 4'd4};
         5'd11:   t = {4'd5, 4'd6};
         5'd12:   t = {4'd6, 4'd7};
         5'd13:   t = {4'd7, 4'd8};
         5'd14:   t = {4'd8, 4'd9};
         5'd15:   t = {4'd9, 4'd10};
         5'd16:   t = {4'd1, 4'd4};
         5'd17:   t = {4'd2, 4'd5};
         5'd18:   t = {4'd3, 4'd6};
         5'd19:   t = {4'd4, 4'd7};
         5'd20:   t = {4'd5, 4'd8};
         5'd21:   t = {4'd6, 4'd9};
         5'd22:   t = {4'd1, 4'd3};
         5'd23:   t = {4'd4, 4'd6};
         5'd24:   t = {4'd5, 4'd7};
         5'd25:   t = {4'd6, 4'd8};
         5'd26:   t = {4'd7, 4'd9};
         5'd27:   t = {4'd8, 4'd10};
         5'd28:   t = {4'd1, 4'd6};
         5'd29:   t = {4'd2, 4'd7};
         5'd30:   t = {4'd3, 4'd8};
         default: t = {4'd4, 4'd9};
      endcase
      return t;
   endfunction

   logic [1:0]       state_reg, state_next;
   logic [10:1]      g1_reg, g1_next, g2_reg, g2_next;
   logic [10:1]      g1_step, g2_step;
   logic [3:0]       t1_reg, t1_next, t2_reg, t2_next;
   logic [9:0]       phase_reg, phase_next;
   logic [9:0]       chip_idx_reg, chip_idx_next;
   logic [NCO_W-1:0] nco_reg, nco_next, nco_sum;
   logic             nco_carry;
   logic [4:0]       ectr_reg, ectr_next;
   logic             first_reg, first_next;
   logic [1:0]       sample_reg, sample_next;
   logic             epoch_reg, epoch_next;
   logic             chip_bit;
   logic             boundary;
   logic             nav_eff;
   logic [7:0]       taps_in;
   logic [9:0]       phase_in;

   assign {nco_carry, nco_sum} = {1'b0, nco_reg} + {1'b0, code_rate};
   assign g1_step  = {g1_reg[9:1], g1_reg[3] ^ g1_reg[10]};
   assign g2_step  = {g2_reg[9:1], g2_reg[2] ^ g2_reg[3] ^ g2_reg[6] ^ g2_reg[8] ^ g2_reg[9] ^ g2_reg[10]};
   assign chip_bit = g1_reg[10] ^ g2_reg[t1_reg] ^ g2_reg[t2_reg];
   assign taps_in  = phase_taps(sv);
   assign phase_in = (code_phase_init > LAST_CHIP) ? LAST_CHIP : code_phase_init;

   // Bit boundary: first RUN cycle, or the cycle after the EPB-th epoch wrap; stop/rst suppress the transfer.
   assign boundary = (state_reg == S_RUN) && (first_reg || (ectr_reg == EPB)) && !stop && !rst;

`ifdef L1CA_NAV_MOD_EN
   logic nav_reg, nav_next;
   logic underflow_reg, underflow_next;

   assign nav_eff = (boundary && nav_valid) ? nav_bit : nav_reg;

   always_comb begin
      nav_next       = nav_reg;
      underflow_next = underflow_reg;
      if (stop) begin
         nav_next = 1'b0;
      end else begin
         if ((state_reg == S_IDLE) && start) begin
            underflow_next = 1'b0;
         end
         if (boundary) begin
            if (nav_valid) begin
               nav_next = nav_bit;
            end else begin
               underflow_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nav_reg       <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         nav_reg       <= nav_next;
         underflow_reg <= underflow_next;
      end
   end

   assign nav_ready     = boundary;
   assign bit_edge      = boundary;
   assign nav_underflow = underflow_reg;
`else
   logic nav_unused;
   assign nav_unused    = nav_bit ^ nav_valid;
   assign nav_eff       = 1'b0;
   assign nav_ready     = 1'b0;
   assign bit_edge      = 1'b0;
   assign nav_underflow = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      g1_next       = g1_reg;
      g2_next       = g2_reg;
      t1_next       = t1_reg;
      t2_next       = t2_reg;
      phase_next    = phase_reg;
      chip_idx_next = chip_idx_reg;
      nco_next      = nco_reg;
      ectr_next     = ectr_reg;
      first_next    = 1'b0;
      sample_next   = SMP_ZERO;
      epoch_next    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next         = S_LOAD;
               {t1_next, t2_next} = taps_in;
               phase_next         = phase_in;
               g1_next            = LFSR_SEED;
               g2_next            = LFSR_SEED;
               chip_idx_next      = 10'd0;
               nco_next           = '0;
               ectr_next          = 5'd0;
            end
         end
         S_LOAD: begin
            if (chip_idx_reg != phase_reg) begin
               g1_next       = g1_step;
               g2_next       = g2_step;
               chip_idx_next = chip_idx_reg + 10'd1;
            end
            if ((chip_idx_reg == phase_reg) || ((chip_idx_reg + 10'd1) == phase_reg)) begin
               state_next = S_RUN;
               first_next = 1'b1;
            end
         end
         S_RUN: begin
            nco_next    = nco_sum;
            sample_next = (chip_bit ^ nav_eff) ? SMP_NEG : SMP_POS;
            ectr_next   = boundary ? 5'd0 : ectr_reg;
            if (nco_carry) begin
               if (chip_idx_reg == LAST_CHIP) begin
                  chip_idx_next = 10'd0;
                  g1_next       = LFSR_SEED;
                  g2_next       = LFSR_SEED;
                  epoch_next    = 1'b1;
                  ectr_next     = ectr_next + 5'd1;
               end else begin
                  chip_idx_next = chip_idx_reg + 10'd1;
                  g1_next       = g1_step;
                  g2_next       = g2_step;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
      // stop overrides everything, including a start seen in IDLE.
      if (stop) begin
         state_next    = S_IDLE;
         g1_next       = LFSR_SEED;
         g2_next       = LFSR_SEED;
         chip_idx_next = 10'd0;
         nco_next      = '0;
         ectr_next     = 5'd0;
         first_next    = 1'b0;
         sample_next   = SMP_ZERO;
         epoch_next    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         g1_reg       <= LFSR_SEED;
         g2_reg       <= LFSR_SEED;
         t1_reg       <= 4'd2;
         t2_reg       <= 4'd6;
         phase_reg    <= 10'd0;
         chip_idx_reg <= 10'd0;
         nco_reg      <= '0;
         ectr_reg     <= 5'd0;
         first_reg    <= 1'b0;
         sample_reg   <= SMP_ZERO;
         epoch_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         g1_reg       <= g1_next;
         g2_reg       <= g2_next;
         t1_reg       <= t1_next;
         t2_reg       <= t2_next;
         phase_reg    <= phase_next;
         chip_idx_reg <= chip_idx_next;
         nco_reg      <= nco_next;
         ectr_reg     <= ectr_next;
         first_reg    <= first_next;
         sample_reg   <= sample_next;
         epoch_reg    <= epoch_next;
      end
   end

   assign sample_o = sample_reg;
   assign chip_idx = chip_idx_reg;
   assign epoch    = epoch_reg;
   assign busy     = (state_reg != S_IDLE);

endmodule
